serial_deser: RTL and testbench

Serial-to-parallel receiver for the single-bit data streams driven into the flip-flop blocks. It consumes one bit per qualified clock on `din`, frames it with a start bit and a stop bit, and assembles `WIDTH` data bits, LSB first. Each completed word is presented on a one-entry valid/ready output. It sits at the capture end of a serial link and reports overrun and framing faults.

---
 rtl/serial_deser_pkg.sv | 16 +
 rtl/deser_out_buf.sv | 36 +++
 rtl/serial_deser.sv | 84 ++++++++
 tb/tb_serial_deser.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_deser_pkg.sv
// rtl/serial_deser_pkg.sv - shared encodings and line levels for the serial link
package serial_deser_pkg;

  // ST_BREAK holds off start detection after a bad stop until the line idles high
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/deser_out_buf.sv
// rtl/deser_out_buf.sv - one-entry valid/ready holding register with overrun flag
module deser_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        // a word leaving this cycle frees the slot for the incoming one
        if (!dout_valid || dout_ready) begin
          dout       <= word;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - start/stop framed serial receiver, LSB first, into a one-entry buffer
module serial_deser
  import serial_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             shift_en;
  logic             commit;
  logic             bad_stop;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (din_valid) begin
      case (state)
        ST_IDLE:  if (din == START_BIT) state_nxt = ST_DATA;
        ST_DATA:  if (last_bit) state_nxt = ST_STOP;
        ST_STOP:  state_nxt = (din == STOP_BIT) ? ST_IDLE : ST_BREAK;
        ST_BREAK: if (din == IDLE_LEVEL) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    commit   = 1'b0;
    bad_stop = 1'b0;
    if (din_valid) begin
      shift_en = (state == ST_DATA);
      commit   = (state == ST_STOP) && (din == STOP_BIT);
      bad_stop = (state == ST_STOP) && (din != STOP_BIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      if (shift_en) begin
        shreg[cnt] <= din;
        cnt        <= last_bit ? '0 : cnt + CW'(1);
      end
    end
  end

  deser_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (commit),
    .word       (shreg),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - self-checking bench for serial_deser with a frame-level reference model
module tb_serial_deser;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       overrun;
  logic       frame_err;

  int checks;
  int failures;

  // frame-level model: the single buffered word and the expected event counts
  logic       m_valid;
  logic [7:0] m_dout;
  int         exp_ov, exp_fe;
  int         ov_cnt, fe_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       valid_before_stop;

  serial_deser #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun)   ov_cnt++;
    if (frame_err) fe_cnt++;
    if (dout_valid && dout_ready) got_q.push_back(dout);
    if (overrun && frame_err) begin
      failures++;
      $display("FAIL flags_exclusive overrun=%0b frame_err=%0b required not both", overrun, frame_err);
    end
  end

  function automatic logic rdy_f(input int mode, input bit last);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  task automatic clk_step(input logic b, input logic v, input logic rdy, input bit commit, input logic [7:0] w);
    din        = b;
    din_valid  = v;
    dout_ready = rdy;
    @(posedge clk);
    if (m_valid && rdy) exp_q.push_back(m_dout);
    if (commit) begin
      if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_dout  = w;
      end else begin
        exp_ov++;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input logic stop, input int gap, input int rmode);
    for (int i = 0; i < 10; i++) begin
      logic b;
      b = (i == 0) ? 1'b0 : (i == 9) ? stop : w[i-1];
      repeat (gap) clk_step(1'($urandom_range(0, 1)), 1'b0, rdy_f(rmode, 1'b0), 1'b0, w);
      if (i == 9) valid_before_stop = dout_valid;
      clk_step(b, 1'b1, rdy_f(rmode, i == 9), (i == 9) && stop, w);
    end
    if (!stop) exp_fe++;
  endtask

  task automatic drain();
    repeat (3) clk_step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    dout_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    din = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    m_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic compare_queues(input string tag);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d required=%0d", tag, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s_word[%0d] got=%h required=%h", tag, i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", dout_valid); end
    checks++; if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h required=00", dout); end
    checks++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b required=00", overrun, frame_err); end
    ov_cnt = 0; fe_cnt = 0; exp_ov = 0; exp_fe = 0;
    got_q.delete(); exp_q.delete();
    repeat (20) clk_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (dout_valid !== 1'b0 || dout !== 8'h00) begin failures++; $display("FAIL idle_out got=%b/%h required=0/00", dout_valid, dout); end
    checks++; if (ov_cnt !== 0 || fe_cnt !== 0) begin failures++; $display("FAIL idle_flags got=%0d/%0d required=0/0", ov_cnt, fe_cnt); end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, 0, 0);
    checks++; if (valid_before_stop !== 1'b0) begin failures++; $display("FAIL single_early got=%b required=0", valid_before_stop); end
    checks++; if (dout_valid !== 1'b1 || dout !== 8'hA5) begin failures++; $display("FAIL single_out got=%b/%h required=1/a5", dout_valid, dout); end
    repeat (3) clk_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (dout_valid !== 1'b1 || dout !== 8'hA5) begin failures++; $display("FAIL single_hold got=%b/%h required=1/a5", dout_valid, dout); end
    clk_step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    dout_ready = 1'b0;
    checks++; if (dout_valid !== 1'b0 || dout !== 8'hA5) begin failures++; $display("FAIL single_xfer got=%b/%h required=0/a5", dout_valid, dout); end
    compare_queues("single");
  endtask

  task automatic test_gapped();
    send_frame(8'h3C, 1'b1, 3, 0);
    checks++; if (valid_before_stop !== 1'b0) begin failures++; $display("FAIL gapped_early got=%b required=0", valid_before_stop); end
    checks++; if (dout_valid !== 1'b1 || dout !== 8'h3C) begin failures++; $display("FAIL gapped_out got=%b/%h required=1/3c", dout_valid, dout); end
    drain();
    compare_queues("gapped");
  endtask

  task automatic test_overrun();
    int ov0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 0, 0);
    send_frame(8'h22, 1'b1, 0, 0);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got=%b required=1", overrun); end
    checks++; if (dout !== 8'h11 || dout_valid !== 1'b1) begin failures++; $display("FAIL overrun_keep got=%b/%h required=1/11", dout_valid, dout); end
    send_frame(8'h33, 1'b1, 0, 3);
    dout_ready = 1'b0;
    checks++; if (dout !== 8'h33 || dout_valid !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL overrun_swap got=%b/%h/%b required=1/33/0", dout_valid, dout, overrun); end
    clk_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL overrun_count got=%0d required=1", ov_cnt - ov0); end
    drain();
    compare_queues("overrun");
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 0, 0);
    checks++; if (frame_err !== 1'b1 || dout_valid !== 1'b0) begin failures++; $display("FAIL ferr_pulse got=%b/%b required=1/0", frame_err, dout_valid); end
    clk_step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_width got=%b required=0", frame_err); end
    send_frame(8'h01, 1'b1, 0, 0);
    checks++; if (dout !== 8'h01 || dout_valid !== 1'b1) begin failures++; $display("FAIL ferr_recover got=%b/%h required=1/01", dout_valid, dout); end
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_count got=%0d required=1", fe_cnt - fe0); end
    drain();
    compare_queues("ferr");
  endtask

  task automatic test_reset_mid();
    int ov0, fe0;
    logic [7:0] w;
    ov0 = ov_cnt; fe0 = fe_cnt;
    w = 8'hF0;
    clk_step(1'b0, 1'b1, 1'b0, 1'b0, w);
    for (int i = 0; i < 4; i++) clk_step(w[i], 1'b1, 1'b0, 1'b0, w);
    do_reset(1);
    send_frame(8'h0F, 1'b1, 0, 0);
    checks++; if (dout !== 8'h0F || dout_valid !== 1'b1) begin failures++; $display("FAIL rstmid_out got=%b/%h required=1/0f", dout_valid, dout); end
    drain();
    checks++; if (ov_cnt !== ov0 || fe_cnt !== fe0) begin failures++; $display("FAIL rstmid_flags got=%0d/%0d required=%0d/%0d", ov_cnt, fe_cnt, ov0, fe0); end
    compare_queues("rstmid");
  endtask

  task automatic test_random();
    ov_cnt = 0; fe_cnt = 0; exp_ov = 0; exp_fe = 0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] w;
      logic good;
      w    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(w, good, $urandom_range(0, 2), 2);
      if (!good) clk_step(1'b1, 1'b1, rdy_f(2, 1'b0), 1'b0, 8'h00);
      if (m_valid) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== m_dout) begin
          failures++;
          $display("FAIL rand_out[%0d] got=%b/%h required=1/%h", n, dout_valid, dout, m_dout);
        end
      end
    end
    drain();
    checks++; if (ov_cnt !== exp_ov) begin failures++; $display("FAIL rand_overruns got=%0d required=%0d", ov_cnt, exp_ov); end
    checks++; if (fe_cnt !== exp_fe) begin failures++; $display("FAIL rand_frame_errs got=%0d required=%0d", fe_cnt, exp_fe); end
    compare_queues("rand");
  endtask

  initial begin
    checks = 0; failures = 0;
    m_valid = 1'b0; m_dout = 8'h00;
    exp_ov = 0; exp_fe = 0; ov_cnt = 0; fe_cnt = 0;
    valid_before_stop = 1'b0;
    rst = 1'b0; din = 1'b1; din_valid = 1'b0; dout_ready = 1'b0;
    test_reset();
    test_single();
    test_gapped();
    test_overrun();
    test_frame_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
